write_seq: RTL and testbench

Write-pulse sequencer for the NMC write path. Accepts one write request (address + data word) over a valid/ready handshake, latches it, and drives a fixed setup / pulse / hold sequence onto the word-line and bit-line controls. Its `dff_en` and `bl_data` outputs feed the downstream single-bit DFF bank (one flop per bit) that holds bit-line data during the pulse. All sequencing is freezable by the global enable `sys_en`.

---
 rtl/write_seq.sv | 167 ++++++++++++++++
 tb/tb_write_seq.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/write_seq.sv
// write_seq : write-pulse sequencer for the NMC write path.
//
// Accepts one write request (address + data) over valid/ready, latches it and
// plays a fixed SETUP / PULSE / HOLD / DONE sequence onto the word-line and
// bit-line controls. dff_en/bl_data feed the downstream per-bit DFF bank that
// holds bit-line data while the pulse is applied.
//
// Ports
//   sys_clk    in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   sys_en     in   global enable; 0 freezes state, counter and all outputs
//   req_valid  in   write request present
//   req_ready  out  (state==IDLE) & sys_en  (only combinational output)
//   req_addr   in   [ADDR_W] target word line
//   req_data   in   [DATA_W] write data
//   wl_addr    out  [ADDR_W] latched word-line address
//   wl_en      out  word-line enable, SETUP..HOLD
//   bl_data    out  [DATA_W] latched data, to DFF bank d
//   dff_en     out  one-cycle load strobe (first SETUP cycle), to DFF bank enable
//   wr_pulse   out  write pulse, PULSE state
//   done       out  one-cycle completion strobe, DONE state
module write_seq #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 6,
  parameter int T_SETUP = 2,
  parameter int T_PULSE = 4,
  parameter int T_HOLD  = 2
) (
  input  logic              sys_clk,
  input  logic              rst_n,
  input  logic              sys_en,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_data,
  output logic [ADDR_W-1:0] wl_addr,
  output logic              wl_en,
  output logic [DATA_W-1:0] bl_data,
  output logic              dff_en,
  output logic              wr_pulse,
  output logic              done
);

  localparam int T_SP  = (T_SETUP > T_PULSE) ? T_SETUP : T_PULSE;
  localparam int T_MAX = (T_SP > T_HOLD) ? T_SP : T_HOLD;
  localparam int CNT_W = (T_MAX < 1) ? 1 : $clog2(T_MAX + 1);

  localparam logic [CNT_W-1:0] LD_SETUP = CNT_W'(T_SETUP - 1);
  localparam logic [CNT_W-1:0] LD_PULSE = CNT_W'(T_PULSE - 1);
  localparam logic [CNT_W-1:0] LD_HOLD  = CNT_W'(T_HOLD - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_PULSE = 3'd2,
    S_HOLD  = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] wl_addr_q, wl_addr_d;
  logic [DATA_W-1:0] bl_data_q, bl_data_d;
  logic              wl_en_q, wl_en_d;
  logic              wr_pulse_q, wr_pulse_d;
  logic              dff_en_q, dff_en_d;
  logic              done_q, done_d;
  logic              accept;
  logic              cnt_zero;

  assign req_ready = (state_q == S_IDLE) & sys_en;
  assign accept    = req_ready & req_valid;
  assign cnt_zero  = (cnt_q == '0);

  // Next state / counter. Phase counters are loaded with T-1 on entry so each
  // phase lasts exactly T enabled cycles.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wl_addr_d = wl_addr_q;
    bl_data_d = bl_data_q;
    if (sys_en) begin
      unique case (state_q)
        S_IDLE: begin
          if (accept) begin
            state_d   = S_SETUP;
            cnt_d     = LD_SETUP;
            wl_addr_d = req_addr;
            bl_data_d = req_data;
          end
        end
        S_SETUP: begin
          if (cnt_zero) begin
            state_d = S_PULSE;
            cnt_d   = LD_PULSE;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        S_PULSE: begin
          if (cnt_zero) begin
            state_d = S_HOLD;
            cnt_d   = LD_HOLD;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        S_HOLD: begin
          if (cnt_zero) begin
            state_d = S_DONE;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Registered outputs are decoded from the next state, so they line up with
  // the state they describe. While frozen every output holds, which stretches
  // an active strobe by the freeze length.
  always_comb begin
    wl_en_d    = wl_en_q;
    wr_pulse_d = wr_pulse_q;
    dff_en_d   = dff_en_q;
    done_d     = done_q;
    if (sys_en) begin
      wl_en_d    = (state_d == S_SETUP) | (state_d == S_PULSE) | (state_d == S_HOLD);
      wr_pulse_d = (state_d == S_PULSE);
      done_d     = (state_d == S_DONE);
      // Only the acceptance edge enters SETUP from IDLE, i.e. first SETUP cycle.
      dff_en_d   = accept;
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      wl_addr_q  <= '0;
      bl_data_q  <= '0;
      wl_en_q    <= 1'b0;
      wr_pulse_q <= 1'b0;
      dff_en_q   <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wl_addr_q  <= wl_addr_d;
      bl_data_q  <= bl_data_d;
      wl_en_q    <= wl_en_d;
      wr_pulse_q <= wr_pulse_d;
      dff_en_q   <= dff_en_d;
      done_q     <= done_d;
    end
  end

  assign wl_addr  = wl_addr_q;
  assign bl_data  = bl_data_q;
  assign wl_en    = wl_en_q;
  assign wr_pulse = wr_pulse_q;
  assign dff_en   = dff_en_q;
  assign done     = done_q;

endmodule

// File: tb/tb_write_seq.sv
// Bench for write_seq: two instances (default timing 2/4/2 and minimal 1/1/1)
// share one randomized/directed stimulus stream. A reference model tracks,
// per instance, whether a write is in flight and how many enabled cycles have
// passed since acceptance; expected outputs follow from that index by plain
// arithmetic. Accepted words go into a scoreboard queue and are popped when
// the DUT raises done.
module tb_write_seq;
  localparam int DW = 8;
  localparam int AW = 6;
  localparam int NC = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          sys_en = 1'b0;
  logic          req_valid = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_data = '0;

  logic          rdy[NC], wl_en[NC], wr_pulse[NC], dff_en[NC], done[NC];
  logic [AW-1:0] wl_addr[NC];
  logic [DW-1:0] bl_data[NC];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  write_seq #(.DATA_W(DW), .ADDR_W(AW), .T_SETUP(2), .T_PULSE(4), .T_HOLD(2)) u0 (
    .sys_clk(clk), .rst_n(rst_n), .sys_en(sys_en), .req_valid(req_valid),
    .req_ready(rdy[0]), .req_addr(req_addr), .req_data(req_data),
    .wl_addr(wl_addr[0]), .wl_en(wl_en[0]), .bl_data(bl_data[0]),
    .dff_en(dff_en[0]), .wr_pulse(wr_pulse[0]), .done(done[0]));

  write_seq #(.DATA_W(DW), .ADDR_W(AW), .T_SETUP(1), .T_PULSE(1), .T_HOLD(1)) u1 (
    .sys_clk(clk), .rst_n(rst_n), .sys_en(sys_en), .req_valid(req_valid),
    .req_ready(rdy[1]), .req_addr(req_addr), .req_data(req_data),
    .wl_addr(wl_addr[1]), .wl_en(wl_en[1]), .bl_data(bl_data[1]),
    .dff_en(dff_en[1]), .wr_pulse(wr_pulse[1]), .done(done[1]));

  always #5 clk = ~clk;

  function automatic int ts(int c); return (c == 0) ? 2 : 1; endfunction
  function automatic int tp(int c); return (c == 0) ? 4 : 1; endfunction
  function automatic int th(int c); return (c == 0) ? 2 : 1; endfunction
  function automatic int tot(int c); return ts(c) + tp(c) + th(c) + 1; endfunction

  // Reference model: k = enabled cycles since acceptance (1..tot).
  bit            m_busy[NC];
  int            m_k[NC];
  logic [AW-1:0] m_addr[NC];
  logic [DW-1:0] m_data[NC];
  logic [AW+DW-1:0] sb0[$];
  logic [AW+DW-1:0] sb1[$];

  initial begin
    for (int c = 0; c < NC; c++) begin
      m_busy[c] = 0; m_k[c] = 0; m_addr[c] = '0; m_data[c] = '0;
    end
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        for (int c = 0; c < NC; c++) begin
          m_busy[c] = 0; m_k[c] = 0; m_addr[c] = '0; m_data[c] = '0;
        end
        sb0.delete();
        sb1.delete();
      end else if (sys_en) begin
        for (int c = 0; c < NC; c++) begin
          if (!m_busy[c]) begin
            if (req_valid) begin
              m_busy[c] = 1; m_k[c] = 1;
              m_addr[c] = req_addr; m_data[c] = req_data;
              if (c == 0) sb0.push_back({req_addr, req_data});
              else        sb1.push_back({req_addr, req_data});
            end
          end else if (m_k[c] == tot(c)) begin
            m_busy[c] = 0; m_k[c] = 0;
          end else begin
            m_k[c] = m_k[c] + 1;
          end
        end
      end
    end
  end

  // Monitor: per-cycle output check plus scoreboard pop on each done strobe.
  initial begin
    logic dprev[NC];
    for (int c = 0; c < NC; c++) dprev[c] = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      for (int c = 0; c < NC; c++) begin
        int  k;
        bit  b;
        logic [4:0] e, a;
        logic [AW+DW-1:0] w;
        k = m_k[c];
        b = m_busy[c];
        e = {(!b && sys_en),
             (b && k <= ts(c) + tp(c) + th(c)),
             (b && k > ts(c) && k <= ts(c) + tp(c)),
             (b && k == 1),
             (b && k == tot(c))};
        a = {rdy[c], wl_en[c], wr_pulse[c], dff_en[c], done[c]};
        n_tests++;
        if (a !== e || wl_addr[c] !== m_addr[c] || bl_data[c] !== m_data[c]) begin
          n_fail++;
          $display("FAIL outputs cfg%0d cyc%0d: got rdy/wl/wp/dff/done=%b addr=%h data=%h, expected %b addr=%h data=%h",
                   c, cyc, a, wl_addr[c], bl_data[c], e, m_addr[c], m_data[c]);
        end
        if (rst_n && done[c] === 1'b1 && dprev[c] !== 1'b1) begin
          n_tests++;
          if ((c == 0 && sb0.size() == 0) || (c == 1 && sb1.size() == 0)) begin
            n_fail++;
            $display("FAIL scoreboard cfg%0d cyc%0d: done with no accepted write, got addr=%h data=%h, expected none",
                     c, cyc, wl_addr[c], bl_data[c]);
          end else begin
            w = (c == 0) ? sb0.pop_front() : sb1.pop_front();
            if ({wl_addr[c], bl_data[c]} !== w) begin
              n_fail++;
              $display("FAIL scoreboard cfg%0d cyc%0d: got addr=%h data=%h, expected addr=%h data=%h",
                       c, cyc, wl_addr[c], bl_data[c], w[AW+DW-1:DW], w[DW-1:0]);
            end
          end
        end
        dprev[c] = done[c];
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  initial begin
    // Reset, then a single write (0x15/0xA5).
    rst_n = 1'b0; sys_en = 1'b1;
    step(3);
    rst_n = 1'b1;
    step(2);
    req_valid = 1'b1; req_addr = 6'h15; req_data = 8'hA5;
    step(1);
    // Second request pending during busy; accepted only when idle again.
    req_addr = 6'h2A; req_data = 8'h3C;
    step(11);
    req_valid = 1'b0;
    step(12);

    // Freeze during PULSE for 3 cycles.
    req_valid = 1'b1; req_addr = 6'h07; req_data = 8'h5E;
    step(1);
    req_valid = 1'b0;
    step(3);
    sys_en = 1'b0;
    step(3);
    sys_en = 1'b1;
    step(14);

    // Asynchronous reset during HOLD, then a normal request.
    req_valid = 1'b1; req_addr = 6'h33; req_data = 8'hC3;
    step(1);
    req_valid = 1'b0;
    step(7);
    #1 rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(1);
    req_valid = 1'b1; req_addr = 6'h11; req_data = 8'h99;
    step(1);
    // Valid toggled with changing data while busy.
    for (int i = 0; i < 10; i++) begin
      req_valid = i[0];
      req_addr  = AW'($urandom);
      req_data  = DW'($urandom);
      step(1);
    end
    req_valid = 1'b0;
    step(12);

    // Randomized traffic with random freezes.
    for (int i = 0; i < 800; i++) begin
      sys_en    = ($urandom_range(0, 7) != 0);
      req_valid = ($urandom_range(0, 2) != 0);
      req_addr  = AW'($urandom);
      req_data  = DW'($urandom);
      if (i == 400) begin
        #1 rst_n = 1'b0;
        #1 rst_n = 1'b1;
      end
      step(1);
    end

    // Drain: every accepted write must have completed.
    sys_en = 1'b1; req_valid = 1'b0;
    step(20);
    n_tests++;
    if (sb0.size() != 0 || sb1.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d/%0d writes outstanding, expected 0/0", sb0.size(), sb1.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
